// File: rtl/data_sram_resp.sv
// data_sram_resp: memory-side responder for the data-SRAM request/response
// interface. Accepts reads/writes (addr_ok), commits byte-wise writes into an
// internal word RAM and returns in-order data_ok/rdata after a minimum latency.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-high reset
//   data_sram_req   request valid
//   data_sram_wr    1 = write, 0 = read
//   data_sram_addr  byte address, bits [ADDR_W-1:2] select the word
//   data_sram_wstrb byte-lane write enables
//   data_sram_wdata write data
//   resp_hold       while 1, no response is issued
//   data_sram_addr_ok  request accepted when high together with req
//   data_sram_data_ok  registered one-cycle response pulse
//   data_sram_rdata    registered response data
module data_sram_resp #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2,
    parameter int LAT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    input  logic        resp_hold,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int WORDS = 1 << (ADDR_W - 2);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int AW    = $clog2(LAT + 1);

    logic [31:0]       mem    [WORDS];
    logic [31:0]       q_data [DEPTH];
    logic [AW-1:0]     q_age  [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [ADDR_W-3:0] idx;
    logic              push;
    logic              pop;
    logic              head_ok;
    logic              unused_addr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign idx         = data_sram_addr[ADDR_W-1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_W], data_sram_addr[1:0]};

    assign data_sram_addr_ok = !reset && (count < CW'(DEPTH));
    assign push = data_sram_req && data_sram_addr_ok;

    // The stored age lags the accept edge by one, so the head becomes
    // eligible one cycle early; the registered data_ok then lands exactly
    // LAT cycles after the accept cycle.
    assign head_ok = (int'(q_age[head]) + 1) >= (LAT - 1);
    assign pop     = (count != '0) && head_ok && !resp_hold;

    // RAM is deliberately not reset; reads use the pre-edge contents.
    always_ff @(posedge clk) begin
        if (push && data_sram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_wstrb[b]) begin
                    mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
    end

    // Entry payload/age need no reset: count alone marks validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (q_age[i] != AW'(LAT)) begin
                q_age[i] <= q_age[i] + AW'(1);
            end
        end
        if (push) begin
            q_age[tail]  <= '0;
            q_data[tail] <= data_sram_wr ? 32'h0 : mem[idx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= nxt(tail);
            end
            if (pop) begin
                head <= nxt(head);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sram_data_ok <= 1'b0;
            data_sram_rdata   <= 32'h0;
        end else begin
            data_sram_data_ok <= pop;
            if (pop) begin
                data_sram_rdata <= q_data[head];
            end
        end
    end

endmodule
